csa_accum: RTL and testbench

Parametrised, pipelined three-operand carry-save adder with an optional running accumulator. It generalises the team's fixed 4-bit three-input carry-save adder to `WIDTH`-bit operands. It adds a valid/ready handshake, a two-stage pipeline and an accumulate mode in which each beat's three-operand sum is added into a `ACC_W`-bit running total. It sits between operand producers (e.g. partial-product generators) and any consumer that needs a settled binary sum.

---
 rtl/csa_pkg.sv | 12 +
 rtl/csa_row.sv | 34 +++
 rtl/csa_accum.sv | 132 +++++++++++++
 tb/tb_csa_accum.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared constants and helpers for the carry-save accumulator.
package csa_pkg;

   localparam logic CSA_MODE_SUM = 1'b0;
   localparam logic CSA_MODE_ACC = 1'b1;

   // Width that holds any sum of three w-bit unsigned operands exactly.
   function automatic int csa_sum_w(input int w);
      return w + 2;
   endfunction

endpackage

// File: rtl/csa_row.sv
// One row of full adders compressing three WIDTH-bit vectors into sum and carry
// vectors, plus the single-bit full adder it is built from.
module csa_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module csa_row
   import csa_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry
);
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      csa_fa u_fa (
         .a  (a[gi]),
         .b  (b[gi]),
         .ci (c[gi]),
         .s  (sum[gi]),
         .co (carry[gi])
      );
   end
endmodule

// File: rtl/csa_accum.sv
// Two-stage three-operand carry-save adder with optional running accumulator.
// Define CSA_ACC_OVF_EN to build the sticky accumulator overflow flag.
module csa_accum
   import csa_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] z,
   input  logic             in_mode,
   input  logic             in_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             ovf
);
   localparam int TW = csa_sum_w(WIDTH);

   logic [WIDTH-1:0] s1, c1;
   logic             v1_q, v1_d, mode1_q, mode1_d, clr1_q, clr1_d;
   logic [WIDTH-1:0] s1_q, s1_d;
   logic [WIDTH:0]   c1_q, c1_d;
   logic             v2_q, v2_d;
   logic [ACC_W-1:0] out_q, out_d, acc_q, acc_d;
   logic             adv1;
   logic [TW-1:0]    t;
   logic [ACC_W-1:0] t_ext;

   csa_row #(.WIDTH(WIDTH)) u_row (
      .a     (x),
      .b     (y),
      .c     (z),
      .sum   (s1),
      .carry (c1)
   );

   assign adv1     = !v2_q || out_ready;
   assign in_ready = !v1_q || adv1;
   assign t        = {2'b00, s1_q} + {1'b0, c1_q};

   always_comb begin
      t_ext         = '0;
      t_ext[TW-1:0] = t;
   end

`ifdef CSA_ACC_OVF_EN
   logic             ovf_q, ovf_d;
   logic [ACC_W:0]   acc_sum;
   assign acc_sum = {1'b0, acc_q} + {1'b0, t_ext};
   assign ovf     = ovf_q;
`else
   logic [ACC_W-1:0] acc_sum;
   assign acc_sum = acc_q + t_ext;
   assign ovf     = 1'b0;
`endif

   always_comb begin
      v1_d    = v1_q;
      s1_d    = s1_q;
      c1_d    = c1_q;
      mode1_d = mode1_q;
      clr1_d  = clr1_q;
      v2_d    = v2_q;
      out_d   = out_q;
      acc_d   = acc_q;
`ifdef CSA_ACC_OVF_EN
      ovf_d   = ovf_q;
`endif
      if (in_ready) begin
         v1_d = in_valid;
         if (in_valid) begin
            s1_d    = s1;
            c1_d    = {c1, 1'b0};
            mode1_d = in_mode;
            clr1_d  = in_clr;
         end
      end
      // Accumulator moves only when a valid beat enters stage 2.
      if (adv1) begin
         v2_d = v1_q;
         if (v1_q) begin
            if (mode1_q == CSA_MODE_SUM) begin
               out_d = t_ext;
            end else begin
               acc_d = clr1_q ? t_ext : acc_sum[ACC_W-1:0];
               out_d = acc_d;
`ifdef CSA_ACC_OVF_EN
               ovf_d = clr1_q ? 1'b0 : (ovf_q | acc_sum[ACC_W]);
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         s1_q    <= '0;
         c1_q    <= '0;
         mode1_q <= 1'b0;
         clr1_q  <= 1'b0;
         v2_q    <= 1'b0;
         out_q   <= '0;
         acc_q   <= '0;
`ifdef CSA_ACC_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         v1_q    <= v1_d;
         s1_q    <= s1_d;
         c1_q    <= c1_d;
         mode1_q <= mode1_d;
         clr1_q  <= clr1_d;
         v2_q    <= v2_d;
         out_q   <= out_d;
         acc_q   <= acc_d;
`ifdef CSA_ACC_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign out_valid = v2_q;
   assign out_data  = out_q;

endmodule

// File: tb/tb_csa_accum.sv
// Bench for csa_accum: directed table and corner sequences on a 4/8 instance,
// randomized scoreboard run on a 7/9 instance.
module tb_csa_accum;

   localparam bit OVF_ON =
`ifdef CSA_ACC_OVF_EN
      1'b1;
`else
      1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       a_in_valid = 0, a_in_mode = 0, a_in_clr = 0, a_out_ready = 1;
   logic       a_in_ready, a_out_valid, a_ovf;
   logic [3:0] a_x = 0, a_y = 0, a_z = 0;
   logic [7:0] a_out_data;

   logic       b_in_valid = 0, b_in_mode = 0, b_in_clr = 0, b_out_ready = 1;
   logic       b_in_ready, b_out_valid, b_ovf;
   logic [6:0] b_x = 0, b_y = 0, b_z = 0;
   logic [8:0] b_out_data;

   csa_accum #(.WIDTH(4), .ACC_W(8)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .x(a_x), .y(a_y), .z(a_z), .in_mode(a_in_mode), .in_clr(a_in_clr),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .ovf(a_ovf)
   );

   csa_accum #(.WIDTH(7), .ACC_W(9)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .x(b_x), .y(b_y), .z(b_z), .in_mode(b_in_mode), .in_clr(b_in_clr),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .ovf(b_ovf)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0] x, y, z;
      logic       mode, clr;
      logic [7:0] exp;
      logic       exp_ovf;
   } vec_t;

   localparam int NT = 13;
   vec_t tbl[NT];

   typedef struct {
      int d;
      bit o;
   } exp_t;
   exp_t sb[$];

   task automatic drive_a(input logic [3:0] x, y, z, input logic mode, clr);
      a_in_valid = 1; a_x = x; a_y = y; a_z = z; a_in_mode = mode; a_in_clr = clr;
   endtask

   initial begin
      int   acc_m, sent, cyc, t;
      bit   ovf_m;
      exp_t e;

      tbl[0]  = '{4'd15, 4'd15, 4'd15, 1'b0, 1'b0, 8'd45,  1'b0};
      tbl[1]  = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b0, 8'd0,   1'b0};
      tbl[2]  = '{4'd1,  4'd2,  4'd3,  1'b0, 1'b1, 8'd6,   1'b0};
      tbl[3]  = '{4'd9,  4'd6,  4'd3,  1'b0, 1'b0, 8'd18,  1'b0};
      tbl[4]  = '{4'd15, 4'd15, 4'd15, 1'b1, 1'b1, 8'd45,  1'b0};
      tbl[5]  = '{4'd15, 4'd15, 4'd15, 1'b1, 1'b0, 8'd90,  1'b0};
      tbl[6]  = '{4'd15, 4'd15, 4'd15, 1'b1, 1'b0, 8'd135, 1'b0};
      tbl[7]  = '{4'd15, 4'd15, 4'd15, 1'b1, 1'b0, 8'd180, 1'b0};
      tbl[8]  = '{4'd15, 4'd15, 4'd15, 1'b1, 1'b0, 8'd225, 1'b0};
      tbl[9]  = '{4'd15, 4'd15, 4'd15, 1'b1, 1'b0, 8'd14,  OVF_ON};
      tbl[10] = '{4'd1,  4'd1,  4'd1,  1'b1, 1'b1, 8'd3,   1'b0};
      tbl[11] = '{4'd5,  4'd5,  4'd5,  1'b0, 1'b0, 8'd15,  1'b0};
      tbl[12] = '{4'd2,  4'd2,  4'd2,  1'b1, 1'b0, 8'd9,   1'b0};

      // Power-on reset.
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("rst_a_out_valid", a_out_valid, 0);
      chk("rst_a_out_data",  a_out_data, 0);
      chk("rst_a_ovf",       a_ovf, 0);
      chk("rst_a_in_ready",  a_in_ready, 1);
      chk("rst_b_out_valid", b_out_valid, 0);
      chk("rst_b_in_ready",  b_in_ready, 1);

      // Back-to-back table: result of beat k-2 visible at negedge k.
      for (int k = 0; k < NT + 2; k++) begin
         if (k >= 2) begin
            $display("tbl[%0d] x=%0d y=%0d z=%0d mode=%0d clr=%0d -> data=%0d ovf=%0d",
                     k - 2, tbl[k-2].x, tbl[k-2].y, tbl[k-2].z, tbl[k-2].mode,
                     tbl[k-2].clr, a_out_data, a_ovf);
            chk("tbl_valid", a_out_valid, 1);
            chk("tbl_data",  a_out_data, tbl[k-2].exp);
            chk("tbl_ovf",   a_ovf, tbl[k-2].exp_ovf);
         end
         if (k < NT) drive_a(tbl[k].x, tbl[k].y, tbl[k].z, tbl[k].mode, tbl[k].clr);
         else a_in_valid = 0;
         @(negedge clk);
      end
      chk("tbl_drained", a_out_valid, 0);

      // Backpressure: out_ready low across three edges.
      a_out_ready = 0;
      drive_a(4'd1, 4'd2, 4'd3, 1'b0, 1'b0);
      @(negedge clk);
      drive_a(4'd4, 4'd5, 4'd6, 1'b0, 1'b0);
      @(negedge clk);
      drive_a(4'd7, 4'd8, 4'd9, 1'b0, 1'b0);
      #1;
      chk("stall_in_ready_low", a_in_ready, 0);
      chk("stall_first_data",   a_out_data, 6);
      @(negedge clk);
      $display("stall held data=%0d valid=%0d", a_out_data, a_out_valid);
      chk("stall_hold_valid", a_out_valid, 1);
      chk("stall_hold_data",  a_out_data, 6);
      a_out_ready = 1;
      #1;
      chk("stall_in_ready_comb", a_in_ready, 1);
      @(negedge clk);
      a_in_valid = 0;
      $display("stall out data=%0d", a_out_data);
      chk("stall_second", a_out_data, 15);
      @(negedge clk);
      $display("stall out data=%0d", a_out_data);
      chk("stall_third", a_out_data, 24);
      @(negedge clk);
      chk("stall_no_dup", a_out_valid, 0);

      // Reset with two accumulate beats in flight (acc is 9 going in).
      drive_a(4'd15, 4'd15, 4'd15, 1'b1, 1'b0);
      @(negedge clk);
      drive_a(4'd15, 4'd15, 4'd15, 1'b1, 1'b0);
      @(negedge clk);
      chk("pre_rst_data", a_out_data, 54);
      a_in_valid = 0;
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("midrst_out_valid", a_out_valid, 0);
      chk("midrst_out_data",  a_out_data, 0);
      chk("midrst_ovf",       a_ovf, 0);
      chk("midrst_in_ready",  a_in_ready, 1);
      @(negedge clk);
      chk("midrst_discard", a_out_valid, 0);
      drive_a(4'd1, 4'd0, 4'd0, 1'b1, 1'b0);
      @(negedge clk);
      a_in_valid = 0;
      @(negedge clk);
      $display("post-reset acc beat data=%0d", a_out_data);
      chk("postrst_valid", a_out_valid, 1);
      chk("postrst_data",  a_out_data, 1);

      // Randomized run against the scoreboard.
      acc_m = 0; ovf_m = 0; sent = 0; cyc = 0;
      while ((sent < 10000 || sb.size() > 0) && cyc < 60000) begin
         @(negedge clk);
         b_in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
         b_x         = 7'($urandom);
         b_y         = 7'($urandom);
         b_z         = 7'($urandom);
         b_in_mode   = 1'($urandom);
         b_in_clr    = ($urandom_range(7) == 0);
         b_out_ready = ($urandom_range(3) != 0);
         #1;
         if (b_in_valid && b_in_ready) begin
            t = int'(b_x) + int'(b_y) + int'(b_z);
            if (!b_in_mode) begin
               e.d = t;
            end else if (b_in_clr) begin
               acc_m = t; ovf_m = 0; e.d = t;
            end else begin
               if (acc_m + t >= 512 && OVF_ON) ovf_m = 1;
               acc_m = (acc_m + t) % 512;
               e.d = acc_m;
            end
            e.o = ovf_m;
            sb.push_back(e);
            sent++;
         end
         if (b_out_valid && b_out_ready) begin
            if (sb.size() == 0) begin
               chk("rand_spurious", b_out_valid, 0);
            end else begin
               e = sb.pop_front();
               $display("rand out data=%0d ovf=%0d", b_out_data, b_ovf);
               chk("rand_data", b_out_data, e.d);
               chk("rand_ovf",  b_ovf, e.o);
            end
         end
         cyc++;
      end
      chk("rand_drained", sb.size() + (10000 - sent), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
